// File: rtl/snoop_responder.sv
// snoop_responder: ACE snoop responder, cache side.
// Takes one AC snoop at a time, looks up the tag array, commits the new line state,
// answers on CR and, when DataTransfer=1, streams the line on CD one beat at a time.
// Optional feature macro: SNOOP_RESPONDER_ERR_EN (unsupported ACSNOOP answered with Error).

package snoop_pkg;
  typedef logic [2:0] acprot_t;
  typedef logic [3:0] acsnoop_t;
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } resp_t;
endpackage

module snoop_responder #(
  parameter int SNOOP_ADDR_WIDTH = 64,
  parameter int SNOOP_DATA_WIDTH = 64,
  parameter int LINE_WIDTH       = 512,
  localparam int BEATS           = LINE_WIDTH / SNOOP_DATA_WIDTH,
  localparam int BW              = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [SNOOP_ADDR_WIDTH-1:0] ac_addr_i,
  input  snoop_pkg::acprot_t          ac_prot_i,
  input  snoop_pkg::acsnoop_t         ac_snoop_i,
  input  logic                        ac_valid_i,
  output logic                        ac_ready_o,
  output snoop_pkg::resp_t            cr_resp_o,
  output logic                        cr_valid_o,
  input  logic                        cr_ready_i,
  output logic [SNOOP_DATA_WIDTH-1:0] cd_data_o,
  output logic                        cd_last_o,
  output logic                        cd_valid_o,
  input  logic                        cd_ready_i,
  output logic                        tag_req_o,
  output logic [SNOOP_ADDR_WIDTH-1:0] tag_addr_o,
  input  logic                        tag_rvalid_i,
  input  logic [2:0]                  tag_state_i,
  output logic                        upd_valid_o,
  output logic [2:0]                  upd_state_o,
  output logic                        data_req_o,
  output logic [BW-1:0]               data_beat_o,
  input  logic                        data_rvalid_i,
  input  logic [SNOOP_DATA_WIDTH-1:0] data_rdata_i
);
  import snoop_pkg::*;

  localparam int OFS = $clog2(LINE_WIDTH / 8);
  localparam logic [SNOOP_ADDR_WIDTH-1:0] LINE_MASK = {{(SNOOP_ADDR_WIDTH-OFS){1'b1}}, {OFS{1'b0}}};
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
`ifdef SNOOP_RESPONDER_ERR_EN
  localparam resp_t UNSUP_RESP = 5'b00010;
`else
  localparam resp_t UNSUP_RESP = 5'b00000;
`endif

  typedef enum logic [2:0] {IDLE, LOOKUP, TAG_WAIT, RESP, DATA_REQ, DATA_WAIT, DATA_SEND} state_e;

  state_e                      state_q, state_d;
  logic                        ac_ready_q, ac_ready_d;
  logic [SNOOP_ADDR_WIDTH-1:0] addr_q, addr_d;
  acsnoop_t                    snoop_q, snoop_d;
  resp_t                       resp_q, resp_d;
  logic                        upd_valid_q, upd_valid_d;
  logic [2:0]                  upd_state_q, upd_state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [SNOOP_DATA_WIDTH-1:0] buf_q, buf_d;

  resp_t      lk_resp;
  logic [2:0] lk_new;
  logic       lk_upd;
  logic       is_look, is_dvm;
  logic       unused_prot;

  assign unused_prot = ^ac_prot_i;

  // Classify the incoming snoop: tag-lookup types, DVM, or unsupported.
  always_comb begin
    is_look = ac_snoop_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0111, 4'b1000, 4'b1001, 4'b1101};
    is_dvm  = (ac_snoop_i[3:1] == 3'b111);
  end

  // Hit response and new line state for the captured snoop; a miss leaves everything zero.
  always_comb begin
    lk_resp = '0;
    lk_new  = tag_state_i;
    if (tag_state_i[2]) begin
      unique case (snoop_q)
        4'b0000: begin lk_resp.data_transfer = 1'b1; lk_resp.is_shared = 1'b1; end
        4'b0001: begin
          lk_resp.data_transfer = 1'b1; lk_resp.is_shared = 1'b1;
          lk_resp.pass_dirty = tag_state_i[1]; lk_new = 3'b101;
        end
        4'b0010, 4'b0011: begin
          lk_resp.data_transfer = 1'b1; lk_resp.is_shared = 1'b1;
          lk_new = {1'b1, tag_state_i[1], 1'b1};
        end
        4'b0111: begin
          lk_resp.data_transfer = 1'b1; lk_resp.pass_dirty = tag_state_i[1];
          lk_resp.was_unique = ~tag_state_i[0]; lk_new = 3'b000;
        end
        4'b1001: begin
          lk_resp.data_transfer = tag_state_i[1]; lk_resp.pass_dirty = tag_state_i[1];
          lk_resp.was_unique = ~tag_state_i[0]; lk_new = 3'b000;
        end
        4'b1000: begin
          lk_resp.data_transfer = tag_state_i[1]; lk_resp.pass_dirty = tag_state_i[1];
          lk_resp.is_shared = 1'b1; lk_new = {1'b1, 1'b0, tag_state_i[0]};
        end
        4'b1101: begin lk_resp.was_unique = ~tag_state_i[0]; lk_new = 3'b000; end
        default: ;
      endcase
    end
    lk_upd = tag_state_i[2] && (lk_new != tag_state_i);
  end

  // Next-state and payload logic for the snoop FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    resp_d      = resp_q;
    upd_valid_d = 1'b0;
    upd_state_d = upd_state_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    unique case (state_q)
      IDLE: if (ac_valid_i && ac_ready_q) begin
        addr_d  = ac_addr_i & LINE_MASK;
        snoop_d = ac_snoop_i;
        if (is_look) begin
          resp_d  = '0;
          state_d = LOOKUP;
        end else begin
          // DVM and unsupported types bypass the tag array entirely.
          resp_d  = is_dvm ? resp_t'('0) : UNSUP_RESP;
          state_d = RESP;
        end
      end
      LOOKUP:   state_d = TAG_WAIT;
      TAG_WAIT: if (tag_rvalid_i) begin
        resp_d      = lk_resp;
        upd_valid_d = lk_upd;
        upd_state_d = lk_new;
        state_d     = RESP;
      end
      RESP:      if (cr_ready_i) state_d = resp_q.data_transfer ? DATA_REQ : IDLE;
      DATA_REQ:  state_d = DATA_WAIT;
      DATA_WAIT: if (data_rvalid_i) begin
        buf_d   = data_rdata_i;
        state_d = DATA_SEND;
      end
      DATA_SEND: if (cd_ready_i) begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d  = beat_q + BW'(1);
          state_d = DATA_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    ac_ready_d = (state_d == IDLE);
  end

  // State and payload registers; reset aborts any snoop in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ac_ready_q  <= 1'b0;
      addr_q      <= '0;
      snoop_q     <= '0;
      resp_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_state_q <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ac_ready_q  <= ac_ready_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      resp_q      <= resp_d;
      upd_valid_q <= upd_valid_d;
      upd_state_q <= upd_state_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
    end
  end

  assign ac_ready_o  = ac_ready_q;
  assign cr_valid_o  = (state_q == RESP);
  assign cr_resp_o   = resp_q;
  assign cd_valid_o  = (state_q == DATA_SEND);
  assign cd_data_o   = buf_q;
  assign cd_last_o   = (state_q == DATA_SEND) && (beat_q == LAST_BEAT);
  assign tag_req_o   = (state_q == LOOKUP);
  assign tag_addr_o  = addr_q;
  assign upd_valid_o = upd_valid_q;
  assign upd_state_o = upd_state_q;
  assign data_req_o  = (state_q == DATA_REQ);
  assign data_beat_o = beat_q;

endmodule
